exp_src_arbiter: RTL and testbench

- Upstream feeder for CP0: captures three asynchronous external exception/interrupt request lines, synchronizes and edge-detects them, holds them pending and applies a software mask.
- Presents at most one request at a time to CP0 on one-hot ExpSrc0..2.
- Handshakes with CP0 using HasExp as the acknowledge and IsEret as end-of-service, with an acknowledge timeout.

---
 rtl/exp_src_arbiter_pkg.sv | 23 ++
 rtl/exp_src_arbiter_irq_sync_edge.sv | 42 ++++
 rtl/exp_src_arbiter.sv | 155 +++++++++++++++
 tb/tb_exp_src_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_src_arbiter_pkg.sv
// Shared definitions for the CP0 exception source arbiter.
// Holds the FSM state encoding, the "no source" marker used for in_service,
// the number of request lines and a small priority helper.
package exp_src_arbiter_pkg;

  localparam int         NUM_SRC = 3;
  localparam logic [1:0] NO_SRC  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // Index of the lowest set bit (bit0 = highest priority); NO_SRC if none.
  function automatic logic [1:0] lowest_src(input logic [NUM_SRC-1:0] req);
    if (req[0]) return 2'd0;
    if (req[1]) return 2'd1;
    if (req[2]) return 2'd2;
    return NO_SRC;
  endfunction

endpackage

// File: rtl/exp_src_arbiter_irq_sync_edge.sv
// irq_sync_edge: brings one asynchronous request line into the clk domain
// through a SYNC_STAGES flop chain and emits a one-cycle pulse on each
// rising edge of the synchronized value.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous active-high reset
//   din   - raw asynchronous request line
//   rise  - one-cycle pulse when the synchronized line goes 0 -> 1
module irq_sync_edge
  import exp_src_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the raw line in at bit 0; the top bit is the synchronized value.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Level-held inputs give a single pulse because prev follows the sync output.
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/exp_src_arbiter.sv
// exp_src_arbiter: upstream feeder for CP0. Synchronizes and edge-detects
// three external request lines, holds them pending under a software mask and
// presents at most one of them to CP0 at a time on one-hot ExpSrc0..2.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   irq_in[2:0]           - raw request lines, bit0 highest priority
//   mask_we, mask_din     - mask register write (1 = source enabled)
//   pend_clr[2:0]         - software clear of pending bits
//   err_clr               - clears err_timeout
//   HasExp                - CP0 acknowledge (exception taken)
//   ExpBlock              - CP0 busy; suppresses new grants
//   IsEret                - CP0 executing eret; ends service
//   ExpSrc0..2            - one-hot request to CP0
//   mask_out, pending_out - current mask and pending registers
//   in_service            - serviced source index, 2'b11 when none
//   err_timeout           - sticky: a request was withdrawn on timeout
module exp_src_arbiter
  import exp_src_arbiter_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               err_clr,
  input  logic               HasExp,
  input  logic               ExpBlock,
  input  logic               IsEret,
  output logic               ExpSrc0,
  output logic               ExpSrc1,
  output logic               ExpSrc2,
  output logic [NUM_SRC-1:0] mask_out,
  output logic [NUM_SRC-1:0] pending_out,
  output logic [1:0]         in_service,
  output logic               err_timeout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [NUM_SRC-1:0] rise;

  state_e             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_SRC-1:0] exp_src_q, exp_src_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [1:0]         in_service_q, in_service_d;
  logic               err_q, err_d;

  logic [NUM_SRC-1:0] eligible;
  logic [1:0]         pick;
  logic               grant_ok, ack, timeout, eret;
  logic [NUM_SRC-1:0] ack_clr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
    irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .din   (irq_in[i]),
      .rise  (rise[i])
    );
  end

  // Handshake events, each qualified by the state in which it is meaningful,
  // so HasExp/IsEret arriving in other states are ignored.
  always_comb begin
    eligible = pend_q & mask_q;
    pick     = lowest_src(eligible);
    grant_ok = (state_q == ST_IDLE) && (eligible != '0) && !ExpBlock;
    ack      = (state_q == ST_REQ) && HasExp;
    timeout  = (state_q == ST_REQ) && !HasExp && (cnt_q == CNT_LAST);
    eret     = (state_q == ST_SERVICE) && IsEret;
    ack_clr  = ack ? (NUM_SRC'(1) << grant_q) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= NO_SRC;
      cnt_q        <= '0;
      exp_src_q    <= '0;
      pend_q       <= '0;
      mask_q       <= '1;
      in_service_q <= NO_SRC;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      exp_src_q    <= exp_src_d;
      pend_q       <= pend_d;
      mask_q       <= mask_d;
      in_service_q <= in_service_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (grant_ok) state_d = ST_REQ;
      ST_REQ:     if (ack) state_d = ST_SERVICE;
                  else if (timeout) state_d = ST_IDLE;
      ST_SERVICE: if (eret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath: the grant is committed at the IDLE->REQ edge, so later mask
  // writes do not disturb the request already on ExpSrc. New edges always
  // win over clears in the same cycle, for both pending and err_timeout.
  always_comb begin
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    exp_src_d    = exp_src_q;
    in_service_d = in_service_q;
    mask_d       = mask_we ? mask_din : mask_q;
    pend_d       = (pend_q & ~(pend_clr | ack_clr)) | rise;
    err_d        = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);

    if (grant_ok) begin
      grant_d   = pick;
      exp_src_d = NUM_SRC'(1) << pick;
      cnt_d     = '0;
    end

    if (state_q == ST_REQ) begin
      if (ack) begin
        exp_src_d    = '0;
        in_service_d = grant_q;
      end else if (timeout) begin
        exp_src_d = '0;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (eret) in_service_d = NO_SRC;
  end

  assign ExpSrc0     = exp_src_q[0];
  assign ExpSrc1     = exp_src_q[1];
  assign ExpSrc2     = exp_src_q[2];
  assign mask_out    = mask_q;
  assign pending_out = pend_q;
  assign in_service  = in_service_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_exp_src_arbiter.sv
// Self-checking bench for exp_src_arbiter: a table of per-cycle vectors for
// the basic grant/ack/eret flow, then hand-written sequences for priority
// order, masking, ExpBlock, acknowledge timeout and asynchronous reset.
module tb_exp_src_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] irq_in;
  logic       mask_we;
  logic [2:0] mask_din;
  logic [2:0] pend_clr;
  logic       err_clr;
  logic       HasExp;
  logic       ExpBlock;
  logic       IsEret;
  logic       ExpSrc0, ExpSrc1, ExpSrc2;
  logic [2:0] mask_out;
  logic [2:0] pending_out;
  logic [1:0] in_service;
  logic       err_timeout;

  int total = 0;
  int bad   = 0;

  exp_src_arbiter #(
    .SYNC_STAGES(2),
    .ACK_TIMEOUT(15),
    .CNT_W(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .mask_we     (mask_we),
    .mask_din    (mask_din),
    .pend_clr    (pend_clr),
    .err_clr     (err_clr),
    .HasExp      (HasExp),
    .ExpBlock    (ExpBlock),
    .IsEret      (IsEret),
    .ExpSrc0     (ExpSrc0),
    .ExpSrc1     (ExpSrc1),
    .ExpSrc2     (ExpSrc2),
    .mask_out    (mask_out),
    .pending_out (pending_out),
    .in_service  (in_service),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] irq;
    logic       has_exp;
    logic       is_eret;
    logic [2:0] exp_src;
    logic [2:0] pend;
    logic [1:0] ins;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [2:0] srcVec();
    return {ExpSrc2, ExpSrc1, ExpSrc0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    irq_in = v.irq;
    HasExp = v.has_exp;
    IsEret = v.is_eret;
  endtask

  // Drop all lines long enough that the next rise is a fresh edge.
  task automatic settle();
    irq_in = 3'b000;
    repeat (4) tick();
  endtask

  task automatic waitGrant(input int idx);
    logic [2:0] s;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      s = srcVec();
      checkOutput("onehot", 32'($countones(s) <= 1), 32'd1);
      if (s != 3'b000) seen = 1'b1;
    end
    checkOutput("grant_seen", 32'(seen), 32'd1);
    checkOutput("grant_src", 32'(srcVec()), 32'(3'b001 << idx));
  endtask

  task automatic ackSrc(input int idx);
    HasExp = 1'b1;
    tick();
    HasExp = 1'b0;
    checkOutput("ack_src_low", 32'(srcVec()), 32'd0);
    checkOutput("ack_in_service", 32'(in_service), 32'(idx));
  endtask

  task automatic eret();
    IsEret = 1'b1;
    tick();
    IsEret = 1'b0;
    checkOutput("eret_in_service", 32'(in_service), 32'd3);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // irq rises before edge 0; pending at edge 2, grant at edge 3,
    // HasExp sampled at edge 5, eret at edge 7.
    vecs[0] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3};
    vecs[1] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3};
    vecs[2] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b010, 2'd3};
    vecs[3] = '{3'b010, 1'b0, 1'b0, 3'b010, 3'b010, 2'd3};
    vecs[4] = '{3'b010, 1'b0, 1'b0, 3'b010, 3'b010, 2'd3};
    vecs[5] = '{3'b010, 1'b1, 1'b0, 3'b000, 3'b000, 2'd1};
    vecs[6] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 2'd1};
    vecs[7] = '{3'b010, 1'b0, 1'b1, 3'b000, 3'b000, 2'd3};
    vecs[8] = '{3'b010, 1'b0, 1'b0, 3'b000, 3'b000, 2'd3};

    reset = 1'b1; irq_in = '0; mask_we = 1'b0; mask_din = '0; pend_clr = '0;
    err_clr = 1'b0; HasExp = 1'b0; ExpBlock = 1'b0; IsEret = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    checkOutput("rst_src", 32'(srcVec()), 32'd0);
    checkOutput("rst_pend", 32'(pending_out), 32'd0);
    checkOutput("rst_mask", 32'(mask_out), 32'h7);
    checkOutput("rst_ins", 32'(in_service), 32'd3);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);

    $display("[TB] basic flow vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_src", i), 32'(srcVec()), 32'(vecs[i].exp_src));
      checkOutput($sformatf("vec%0d_pend", i), 32'(pending_out), 32'(vecs[i].pend));
      checkOutput($sformatf("vec%0d_ins", i), 32'(in_service), 32'(vecs[i].ins));
    end
    HasExp = 1'b0; IsEret = 1'b0;

    $display("[TB] priority order");
    settle();
    irq_in = 3'b111;
    for (int k = 0; k < 3; k++) begin
      waitGrant(k);
      ackSrc(k);
      eret();
    end
    checkOutput("prio_pend", 32'(pending_out), 32'd0);

    $display("[TB] masking");
    settle();
    mask_we = 1'b1; mask_din = 3'b110;
    tick();
    mask_we = 1'b0;
    checkOutput("mask_write", 32'(mask_out), 32'h6);
    irq_in = 3'b101;
    waitGrant(2);
    ackSrc(2);
    checkOutput("mask_pend_kept", 32'(pending_out), 32'h1);
    mask_we = 1'b1; mask_din = 3'b111;
    tick();
    mask_we = 1'b0;
    checkOutput("mask_no_nest", 32'(srcVec()), 32'd0);
    eret();
    tick();
    checkOutput("mask_regrant0", 32'(srcVec()), 32'h1);
    ackSrc(0);
    eret();

    $display("[TB] ExpBlock");
    settle();
    ExpBlock = 1'b1;
    irq_in = 3'b001;
    for (int c = 0; c < 6; c++) begin
      tick();
      checkOutput("block_src", 32'(srcVec()), 32'd0);
    end
    checkOutput("block_pend", 32'(pending_out), 32'h1);
    ExpBlock = 1'b0;
    tick();
    checkOutput("unblock_src", 32'(srcVec()), 32'h1);
    ackSrc(0);
    eret();

    $display("[TB] acknowledge timeout");
    settle();
    irq_in = 3'b001;
    waitGrant(0);
    for (int c = 0; c < 14; c++) begin
      tick();
      checkOutput("to_held", 32'(srcVec()), 32'h1);
    end
    tick();
    checkOutput("to_drop", 32'(srcVec()), 32'd0);
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    checkOutput("to_pend", 32'(pending_out), 32'h1);
    tick();
    checkOutput("to_regrant", 32'(srcVec()), 32'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checkOutput("err_clr", 32'(err_timeout), 32'd0);
    ackSrc(0);
    eret();

    $display("[TB] asynchronous reset mid-request");
    settle();
    mask_we = 1'b1; mask_din = 3'b110;
    tick();
    mask_we = 1'b0;
    irq_in = 3'b100;
    waitGrant(2);
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_src", 32'(srcVec()), 32'd0);
    checkOutput("areset_pend", 32'(pending_out), 32'd0);
    checkOutput("areset_mask", 32'(mask_out), 32'h7);
    checkOutput("areset_ins", 32'(in_service), 32'd3);
    #1 reset = 1'b0;
    irq_in = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
